// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder word-memory slave.
package mem_responder_pkg;

    localparam int WORD_BYTES = 4;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the control FSM (master) and mem_responder (slave).
interface mem_responder_if;
    import mem_responder_pkg::*;

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              err;

    modport master (output req, we, addr, wdata, input ack, rdata, busy, err);
    modport slave  (input req, we, addr, wdata, output ack, rdata, busy, err);

endinterface

// File: rtl/mem_responder_array.sv
// Word storage: synchronous write, combinational index-addressed read.
module mem_responder_array
    import mem_responder_pkg::*;
#(
    parameter int  DEPTH_WORDS = 256,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    // NOTE: storage carries no reset so it maps onto RAM and survives a controller reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder: IDLE -> WAIT -> RESP handshake over a word array.
// Optional fault checking is enabled by defining MEM_RESPONDER_ERR_EN.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);

    localparam int             IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              fault_q, fault_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              enter_resp;
    logic              req_fault;
    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_we;

    assign req_idx = bus.addr[IDX_W+1:2];

`ifdef MEM_RESPONDER_ERR_EN
    assign req_fault = (bus.addr[1:0] != 2'b00) ||
                       (bus.addr >= ADDR_W'(WORD_BYTES * DEPTH_WORDS));
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.addr[ADDR_W-1:IDX_W+2], bus.addr[1:0]};
    assign req_fault        = 1'b0;
`endif

    // With zero wait states RESP is entered straight from IDLE, so the read uses the live index.
    assign rd_idx = (state_q == IDLE) ? req_idx : idx_q;
    assign mem_we = (state_q == RESP) && we_q && !fault_q;

    mem_responder_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (idx_q),
        .wdata_i (wdata_q),
        .raddr_i (rd_idx),
        .rdata_o (mem_rdata)
    );

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        fault_d    = fault_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        enter_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req) begin
                    we_d    = bus.we;
                    fault_d = req_fault;
                    idx_d   = req_idx;
                    wdata_d = bus.wdata;
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if (enter_resp && !we_d) begin
            rdata_d = fault_d ? '0 : mem_rdata;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            fault_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            fault_q <= fault_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.ack   = (state_q == RESP);
    assign bus.busy  = (state_q != IDLE);
    assign bus.err   = (state_q == RESP) && fault_q;
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (2 and 0 wait states) against an array-based reference model.
module tb_mem_responder;

    localparam int DEPTH_A = 256;
    localparam int WAIT_A  = 2;
    localparam int DEPTH_B = 16;
    localparam int WAIT_B  = 0;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    mem_responder_if ifa ();
    mem_responder_if ifb ();

    mem_responder #(.DEPTH_WORDS(DEPTH_A), .WAIT_CYCLES(WAIT_A)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (ifa.slave)
    );

    mem_responder #(.DEPTH_WORDS(DEPTH_B), .WAIT_CYCLES(WAIT_B)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (ifb.slave)
    );

    int          n_asserts = 0;
    int          n_fail    = 0;
    logic [31:0] mem_a [DEPTH_A];
    logic [31:0] mem_b [DEPTH_B];
    logic [31:0] last_a;
    logic [31:0] last_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_fault(input logic [31:0] a, input int depth);
`ifdef MEM_RESPONDER_ERR_EN
        return ((a % 32'd4) != 32'd0) || (a >= 32'(4 * depth));
`else
        return (a === 32'hxxxx_xxxx) && (depth < 0);
`endif
    endfunction

    function automatic int word_idx(input logic [31:0] a, input int depth);
        return int'((a / 32'd4) % 32'(depth));
    endfunction

    function automatic logic [31:0] rand_addr(input int depth, input int words);
        return 32'($urandom_range(0, words - 1) * 4 + $urandom_range(0, 3)
                   + 4 * depth * $urandom_range(0, 2));
    endfunction

    function automatic logic ack_o(input bit b);   return b ? ifb.ack   : ifa.ack;   endfunction
    function automatic logic busy_o(input bit b);  return b ? ifb.busy  : ifa.busy;  endfunction
    function automatic logic err_o(input bit b);   return b ? ifb.err   : ifa.err;   endfunction
    function automatic logic [31:0] rdata_o(input bit b); return b ? ifb.rdata : ifa.rdata; endfunction

    task automatic drive(input bit b, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (b) begin
            ifb.req = r; ifb.we = w; ifb.addr = a; ifb.wdata = d;
        end else begin
            ifa.req = r; ifa.we = w; ifa.addr = a; ifa.wdata = d;
        end
    endtask

    // Issues one access from mid-cycle, scrambles the inputs while it is in flight,
    // checks cycle-exact ack/busy and the response, then leaves the DUT in its first IDLE cycle.
    task automatic access(input bit b, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input string tag);
        int          wc    = b ? WAIT_B : WAIT_A;
        int          depth = b ? DEPTH_B : DEPTH_A;
        bit          f     = is_fault(a, depth);
        int          ix    = word_idx(a, depth);
        logic [31:0] exp_rd;
        if (w)      exp_rd = b ? last_b : last_a;
        else if (f) exp_rd = 32'h0;
        else        exp_rd = b ? mem_b[ix] : mem_a[ix];
        drive(b, 1'b1, w, a, d);
        @(posedge clk);
        for (int j = 0; j <= wc; j++) begin
            #1;
            if (j == 0) drive(b, 1'b1, ~w, 32'h20, 32'h0);
            else        drive(b, 1'($urandom), 1'($urandom), $urandom, $urandom);
            @(negedge clk);
            check({tag, " busy"}, 32'(busy_o(b)), 32'd1);
            check({tag, " ack"}, 32'(ack_o(b)), 32'(j == wc));
            if (j == wc) begin
                check({tag, " rdata"}, rdata_o(b), exp_rd);
                check({tag, " err"}, 32'(err_o(b)), 32'(f));
            end
            @(posedge clk);
        end
        #1;
        drive(b, 1'b0, 1'b0, $urandom, $urandom);
        @(negedge clk);
        check({tag, " idle_busy"}, 32'(busy_o(b)), 32'd0);
        check({tag, " idle_ack"}, 32'(ack_o(b)), 32'd0);
        if (w && !f) begin
            if (b) mem_b[ix] = d; else mem_a[ix] = d;
        end else if (!w) begin
            if (b) last_b = exp_rd; else last_a = exp_rd;
        end
    endtask

    initial begin
        bit saw_ack;
        rst_a  = 1'b1;
        rst_b  = 1'b1;
        last_a = 32'h0;
        last_b = 32'h0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int b = 0; b < 2; b++) begin
            check("reset busy", 32'(busy_o(b[0])), 32'd0);
            check("reset ack", 32'(ack_o(b[0])), 32'd0);
            check("reset err", 32'(err_o(b[0])), 32'd0);
            check("reset rdata", rdata_o(b[0]), 32'd0);
        end
        rst_a = 1'b0;
        rst_b = 1'b0;

        for (int i = 0; i < 32; i++) access(1'b0, 1'b1, 32'(i * 4), $urandom, "init_a");
        for (int i = 0; i < DEPTH_B; i++) access(1'b1, 1'b1, 32'(i * 4), $urandom, "init_b");

        // Write with inputs redirected to 0x20/0 mid-flight, then read both words back.
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "wr_10");
        access(1'b0, 1'b0, 32'h10, 32'h0, "rd_10");
        check("rd_10 direct", rdata_o(1'b0), 32'hDEADBEEF);
        access(1'b0, 1'b0, 32'h20, 32'h0, "rd_20");

        // Zero-wait read, immediately followed by another request.
        access(1'b1, 1'b0, 32'h10, 32'h0, "b_rd_10");
        access(1'b1, 1'b0, 32'h14, 32'h0, "b_rd_14");

        // Reset in the middle of a write must abort it.
        access(1'b0, 1'b1, 32'h8, 32'hA5A50001, "wr_8");
        access(1'b0, 1'b0, 32'h8, 32'h0, "rd_8");
        drive(1'b0, 1'b1, 1'b1, 32'h8, 32'h12345678);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("rst pre busy", 32'(ifa.busy), 32'd1);
        rst_a = 1'b1;
        #1;
        check("rst busy", 32'(ifa.busy), 32'd0);
        check("rst ack", 32'(ifa.ack), 32'd0);
        check("rst rdata", ifa.rdata, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_a   = 1'b0;
        saw_ack = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ifa.ack) saw_ack = 1'b1;
        end
        check("rst no_ack", 32'(saw_ack), 32'd0);
        last_a = 32'h0;
        access(1'b0, 1'b0, 32'h8, 32'h0, "rd_8_after_rst");
        check("rd_8_after_rst direct", ifa.rdata, 32'hA5A50001);

`ifdef MEM_RESPONDER_ERR_EN
        access(1'b0, 1'b1, 32'h6, 32'h0BADF00D, "err_wr_6");
        access(1'b0, 1'b0, 32'h4, 32'h0, "rd_4_after_err");
        access(1'b0, 1'b0, 32'(4 * DEPTH_A), 32'h0, "err_rd_oor");
        check("err_rd_oor direct", ifa.rdata, 32'h0);
`else
        access(1'b0, 1'b1, 32'(4 * DEPTH_A + 4), 32'hCAFEF00D, "wrap_wr_a");
        access(1'b0, 1'b0, 32'h4, 32'h0, "wrap_rd_a");
        check("wrap_rd_a direct", ifa.rdata, 32'hCAFEF00D);
        access(1'b1, 1'b1, 32'(4 * DEPTH_B + 4), 32'h600DCAFE, "wrap_wr_b");
        access(1'b1, 1'b0, 32'h4, 32'h0, "wrap_rd_b");
        check("wrap_rd_b direct", ifb.rdata, 32'h600DCAFE);
`endif

        for (int i = 0; i < 60; i++) begin
            access(1'b0, 1'($urandom), rand_addr(DEPTH_A, 32), $urandom, "rand_a");
        end
        for (int i = 0; i < 60; i++) begin
            access(1'b1, 1'($urandom), rand_addr(DEPTH_B, DEPTH_B), $urandom, "rand_b");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: number of 32-bit words held; power of two, 4..65536.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states inserted before each response; range 0..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  1  access request from control FSM; sampled only in IDLE.
REQ-006 we  input  1  1 = write (MemWrite), 0 = read; sampled with req.
REQ-007 addr  input  32  byte address; sampled with req.
REQ-008 wdata  input  32  write data; sampled with req.
REQ-009 ack  output  1  one-cycle completion pulse.
REQ-010 rdata  output  32  read data; valid while ack=1.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 err  output  1  access fault; valid while ack=1.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT, RESP; the encoding is defined in the shared package.
REQ-014 In IDLE with req=1 at a rising edge, the block SHALL latch we, addr and wdata, then go to WAIT if WAIT_CYCLES>0, else to RESP.
REQ-015 The WAIT counter SHALL load WAIT_CYCLES-1 on entry and decrement each cycle; WAIT SHALL go to RESP when the counter is 0.
REQ-016 ack SHALL be high for exactly the one cycle spent in RESP; RESP SHALL always return to IDLE.
REQ-017 Acceptance at edge k SHALL put ack high in the cycle after edge k+WAIT_CYCLES.
REQ-018 req, we, addr and wdata SHALL be ignored outside IDLE; changes to them SHALL NOT affect an access in flight.
REQ-019 A new request SHALL be accepted no earlier than the first IDLE cycle after ack, giving a minimum issue period of WAIT_CYCLES+2 cycles.
REQ-020 The word index SHALL be latched addr[log2(DEPTH_WORDS)+1:2].
REQ-021 For a read, rdata SHALL be registered from the array on the edge that enters RESP, and SHALL hold that value until the next RESP.
REQ-022 For a write, the array SHALL update at the edge that leaves RESP; rdata SHALL be unchanged by a write.
REQ-023 A read in the cycle after a write ack to the same word SHALL return the newly written value.
REQ-024 busy SHALL equal (state != IDLE).

Reset
REQ-025 Asserting reset SHALL immediately force IDLE and set ack=0, busy=0, err=0, rdata=0, and clear the wait counter.
REQ-026 Reset during WAIT or RESP SHALL abort the access; no array write SHALL occur and no ack SHALL be produced.
REQ-027 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-028 With MEM_RESPONDER_ERR_EN defined, err SHALL be 1 during RESP if latched addr[1:0]!=0 or addr>=4*DEPTH_WORDS.
REQ-029 With MEM_RESPONDER_ERR_EN defined, a faulted write SHALL NOT modify the array, and a faulted read SHALL return rdata=0.
REQ-030 Without MEM_RESPONDER_ERR_EN, err SHALL be tied to 0, addr[1:0] SHALL be ignored, and out-of-range addresses SHALL wrap modulo DEPTH_WORDS.

Structure
REQ-031 Package mem_responder_pkg SHALL hold the state typedef (IDLE, WAIT, RESP), WORD_BYTES=4 and the 32-bit data width constant.
REQ-032 Sub-module mem_responder_array SHALL implement the word array: synchronous write, index-addressed read, no reset.

Verification
REQ-033 WAIT_CYCLES=2: write 0xDEADBEEF to 0x10 accepted at edge 0 -> busy=1 after edge 0; ack=1 in the cycle after edge 2 only; a later read of 0x10 gives rdata=0xDEADBEEF.
REQ-034 WAIT_CYCLES=0: read of 0x10 accepted at edge 0 -> ack=1 in the cycle after edge 0; a back-to-back req is accepted no earlier than edge 2.
REQ-035 addr/wdata changed to 0x20/0x0 during WAIT of a write to 0x10 -> word 0x10 gets the original data; word 0x20 is unchanged.
REQ-036 reset pulsed in WAIT of a write of 0x12345678 to 0x8 -> no ack; busy=0 and rdata=0 immediately; word 0x8 keeps its old value.
REQ-037 ERR_EN defined: write to 0x6 -> ack=1, err=1, array unchanged; read of 4*DEPTH_WORDS -> err=1, rdata=0. Undefined: write to 4*DEPTH_WORDS+4 -> lands in word 1.
